qproj_mac_lane: RTL and testbench
=================================

Name: qproj_mac_lane

Overview:
- Downstream consumer of the Q-projection byte FIFO, which emits 8-byte frames: 3 zero pad bytes, 4 data bytes, 1 zero pad byte.
- Pops exactly FRAME_LEN bytes per frame from the FIFO and multiplies each by a stored per-position weight byte.
- Accumulates the signed products and presents one dot-product result per frame on a valid/ready output handshake.
- Zero pad bytes flow through the same datapath and contribute nothing to the sum.

Parameters:
- DATA_WIDTH, 8, width of activation and weight bytes (two's complement).
- FRAME_LEN, 8, bytes consumed per result; matches FIFO frame size (DEPTH+1).
- ACC_WIDTH, 20, accumulator/result width; must be >= 2*DATA_WIDTH + $clog2(FRAME_LEN).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- w_load  in  1  load weight vector; honoured only in IDLE.
- w_data  in  DATA_WIDTH*FRAME_LEN  weight vector; bits [DATA_WIDTH-1:0] are position 0.
- fifo_empty  in  1  FIFO empty flag.
- fifo_read_en  out  1  FIFO pop request.
- fifo_read_data  in  DATA_WIDTH  FIFO read data; valid the cycle after fifo_read_en.
- result  out  ACC_WIDTH  signed dot product.
- result_valid  out  1  result available.
- result_ready  in  1  downstream accepts result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0) clears the FSM to IDLE and zeroes all counters, accumulator, rd_vld, weights and outputs.
  - result=0, result_valid=0, fifo_read_en=0, busy=0.
- FSM states: IDLE, RUN, DRAIN, OUT.
- IDLE:
  - w_load=1 latches w_data into the weight bank; state stays IDLE.
  - If !fifo_empty and w_load=0: go to RUN; clear accumulator, issue count and capture count.
  - If w_load and !fifo_empty in the same cycle: the load wins; RUN starts on a later cycle.
- RUN:
  - fifo_read_en = !fifo_empty && (issue_cnt < FRAME_LEN). This is combinational; never asserted while fifo_empty=1.
  - Each asserted pop increments issue_cnt and sets rd_vld for the next cycle.
  - On the pop that makes issue_cnt reach FRAME_LEN, go to DRAIN.
  - Empty FIFO mid-frame stalls with no pop; the partial accumulation is retained indefinitely.
- Capture pipeline, active in RUN and DRAIN:
  - When rd_vld=1: acc <= acc + sext(fifo_read_data) * sext(weight[cap_cnt]); cap_cnt increments.
  - The product is a signed 2*DATA_WIDTH value sign-extended to ACC_WIDTH; no saturation.
  - Wrap-around is impossible within the stated parameter rule.
- DRAIN:
  - No pops.
  - When the capture that brings cap_cnt to FRAME_LEN occurs: go to OUT, result <= final sum, result_valid=1.
- OUT:
  - result and result_valid are held stable until result_ready=1; no pops occur while waiting (backpressure into the FIFO).
  - On the handshake cycle result_valid is deasserted. Next state is RUN if !fifo_empty (counters and accumulator cleared), else IDLE.
- Latency and throughput:
  - Last pop to result_valid = 2 cycles.
  - Back-to-back frames with result_ready tied high: FRAME_LEN+2 cycles per frame.
- Weights are static across frames until reloaded. w_load outside IDLE is ignored; busy tells the loader to wait.
- Reset mid-frame discards the partial sum and the outstanding pop. Bytes already popped are lost, and the FIFO owner must reset alongside this block.

Decomposition:
- Shared package qproj_pkg holds:
  - the state enum (IDLE/RUN/DRAIN/OUT);
  - localparams DATA_WIDTH_DEF=8, FRAME_LEN_DEF=8;
  - a function acc_width(dw, n) returning 2*dw + $clog2(n).
- One sub-module, qproj_mac_unit: a signed DATA_WIDTH x DATA_WIDTH multiply with sign-extended add into an ACC_WIDTH register, plus clear and enable inputs.
- FSM, counters and weight bank stay in the top module.

Test Plan:
- Reset then weights all 1 and frame [0,0,0,1,2,3,4,0], result_ready=1:
  - Expect 8 pops in consecutive cycles, then result=10, result_valid for 1 cycle 2 cycles after the last pop.
- Weights [0,0,0,-1,2,-3,4,0] and data [0,0,0,-128,127,-128,127,0]:
  - Expect result = 128 + 254 + 384 + 508 = 1274. Signedness check.
- FIFO empty toggled mid-frame (empty after 3rd pop for 5 cycles):
  - Expect fifo_read_en=0 throughout the gap; final result equals the uninterrupted result.
- result_ready held 0 for 10 cycles with a second frame queued:
  - Expect result stable and no pops while waiting.
  - After the handshake, RUN restarts the next cycle; the second result is correct and unaffected by the first.
- w_load asserted during RUN with new weights:
  - Expect it ignored for the current frame; reload in IDLE takes effect for the next frame.
- rst_n pulsed low during RUN after 4 pops:
  - Expect immediate IDLE, result_valid=0, fifo_read_en=0, busy=0.
  - A fresh frame after release yields the correct result.

Source files
------------

// File: rtl/qproj_pkg.sv
// Shared types and sizing helpers for the Q-projection MAC lane.
package qproj_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_OUT
  } state_t;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned FRAME_LEN_DEF  = 8;

  // Minimum accumulator width that cannot wrap over a full frame.
  function automatic int unsigned acc_width(input int unsigned dw, input int unsigned n);
    return 2 * dw + $clog2(n);
  endfunction

endpackage

// File: rtl/qproj_mac_unit.sv
// Signed DATA_WIDTH x DATA_WIDTH multiply, sign-extended and accumulated into ACC_WIDTH.
module qproj_mac_unit
  import qproj_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ACC_WIDTH  = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clr,
  input  logic                  i_en,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic [ACC_WIDTH-1:0]  o_sum
);

  logic [2*DATA_WIDTH-1:0] w_a_ext;
  logic [2*DATA_WIDTH-1:0] w_b_ext;
  logic [2*DATA_WIDTH-1:0] w_prod;
  logic [ACC_WIDTH-1:0]    w_prod_ext;
  logic [ACC_WIDTH-1:0]    w_sum;
  logic [ACC_WIDTH-1:0]    r_acc;

  // Low 2*DW bits of the product of sign-extended operands equal the signed product.
  assign w_a_ext    = {{DATA_WIDTH{i_a[DATA_WIDTH-1]}}, i_a};
  assign w_b_ext    = {{DATA_WIDTH{i_b[DATA_WIDTH-1]}}, i_b};
  assign w_prod     = w_a_ext * w_b_ext;
  assign w_prod_ext = {{(ACC_WIDTH-2*DATA_WIDTH){w_prod[2*DATA_WIDTH-1]}}, w_prod};
  assign w_sum      = r_acc + w_prod_ext;
  assign o_sum      = w_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= w_sum;
    end
  end

endmodule

// File: rtl/qproj_mac_lane.sv
// Pops fixed-length frames from the Q-projection FIFO and emits one signed dot product per frame.
module qproj_mac_lane
  import qproj_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned FRAME_LEN  = FRAME_LEN_DEF,
  parameter int unsigned ACC_WIDTH  = 20
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            w_load,
  input  logic [DATA_WIDTH*FRAME_LEN-1:0] w_data,
  input  logic                            fifo_empty,
  output logic                            fifo_read_en,
  input  logic [DATA_WIDTH-1:0]           fifo_read_data,
  output logic [ACC_WIDTH-1:0]            result,
  output logic                            result_valid,
  input  logic                            result_ready,
  output logic                            busy
);

  localparam int unsigned CW = $clog2(FRAME_LEN) + 1;
  localparam int unsigned IW = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] LP_LEN  = CW'(FRAME_LEN);
  localparam logic [CW-1:0] LP_LAST = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] LP_ONE  = CW'(1);

  state_t                r_state;
  logic [CW-1:0]         r_issue_cnt;
  logic [CW-1:0]         r_cap_cnt;
  logic                  r_rd_vld;
  logic [DATA_WIDTH-1:0] r_wbank [FRAME_LEN];
  logic [ACC_WIDTH-1:0]  r_result;
  logic                  r_result_valid;

  logic                  w_pop;
  logic                  w_start;
  logic [DATA_WIDTH-1:0] w_weight;
  logic [ACC_WIDTH-1:0]  w_sum;

  assign w_pop = (r_state == ST_RUN) && !fifo_empty && (r_issue_cnt < LP_LEN);

  // Entering RUN from IDLE (load has priority) or straight out of a completed handshake.
  assign w_start = ((r_state == ST_IDLE) && !w_load && !fifo_empty) ||
                   ((r_state == ST_OUT) && result_ready && !fifo_empty);

  assign w_weight = r_wbank[r_cap_cnt[IW-1:0]];

  qproj_mac_unit #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_start),
    .i_en  (r_rd_vld),
    .i_a   (fifo_read_data),
    .i_b   (w_weight),
    .o_sum (w_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_issue_cnt    <= '0;
      r_cap_cnt      <= '0;
      r_rd_vld       <= 1'b0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      for (int unsigned i = 0; i < FRAME_LEN; i++) begin
        r_wbank[i] <= '0;
      end
    end else begin
      r_rd_vld <= w_pop;
      if (w_pop) begin
        r_issue_cnt <= r_issue_cnt + LP_ONE;
      end
      if (r_rd_vld) begin
        r_cap_cnt <= r_cap_cnt + LP_ONE;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_load) begin
            for (int unsigned i = 0; i < FRAME_LEN; i++) begin
              r_wbank[i] <= w_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
          end else if (w_start) begin
            r_state     <= ST_RUN;
            r_issue_cnt <= '0;
            r_cap_cnt   <= '0;
          end
        end
        ST_RUN: begin
          if (w_pop && (r_issue_cnt == LP_LAST)) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (r_rd_vld && (r_cap_cnt == LP_LAST)) begin
            r_state        <= ST_OUT;
            r_result       <= w_sum;
            r_result_valid <= 1'b1;
          end
        end
        ST_OUT: begin
          if (result_ready) begin
            r_result_valid <= 1'b0;
            if (w_start) begin
              r_state     <= ST_RUN;
              r_issue_cnt <= '0;
              r_cap_cnt   <= '0;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign fifo_read_en = w_pop;
  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_qproj_mac_lane.sv
// Directed bench for qproj_mac_lane with a queue-backed FIFO model.
module tb_qproj_mac_lane;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        w_load;
  logic [63:0] w_data;
  logic        fifo_empty;
  logic        fifo_read_en;
  logic [7:0]  fifo_read_data;
  logic [19:0] result;
  logic        result_valid;
  logic        result_ready;
  logic        busy;

  always #5 clk = ~clk;

  qproj_mac_lane #(
    .DATA_WIDTH (8),
    .FRAME_LEN  (8),
    .ACC_WIDTH  (20)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .w_load         (w_load),
    .w_data         (w_data),
    .fifo_empty     (fifo_empty),
    .fifo_read_en   (fifo_read_en),
    .fifo_read_data (fifo_read_data),
    .result         (result),
    .result_valid   (result_valid),
    .result_ready   (result_ready),
    .busy           (busy)
  );

  logic [7:0] q[$];
  logic       gap;
  logic       en_s;
  logic       empty_s;
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         pops = 0;
  int         first_pop_cyc = 0;
  int         last_pop_cyc = 0;

  // Frames and weights written position 7 .. position 0.
  localparam logic [63:0] F1 = {8'h00, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00, 8'h00, 8'h00};
  localparam logic [63:0] F2 = {8'h00, 8'h7f, 8'h80, 8'h7f, 8'h80, 8'h00, 8'h00, 8'h00};
  localparam logic [63:0] F4 = {8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00};
  localparam logic [63:0] F6 = {8'h00, 8'h07, 8'hfd, 8'h14, 8'h0a, 8'h00, 8'h00, 8'h00};
  localparam logic [63:0] W1 = 64'h0101_0101_0101_0101;
  localparam logic [63:0] W2 = {8'h00, 8'h04, 8'hfd, 8'h02, 8'hff, 8'h00, 8'h00, 8'h00};
  localparam logic [63:0] WT = 64'h0202_0202_0202_0202;
  localparam logic [63:0] W6 = {8'h00, 8'h01, 8'h03, 8'hfe, 8'h05, 8'h00, 8'h00, 8'h00};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic upd_empty();
    fifo_empty = (q.size() == 0) || gap;
  endtask

  task automatic push_frame(input logic [63:0] f);
    for (int i = 0; i < 8; i++) q.push_back(f[8*i +: 8]);
    upd_empty();
  endtask

  // One clock: sample the pop request mid-cycle, then serve it after the edge.
  task automatic step();
    @(negedge clk);
    en_s    = fifo_read_en;
    empty_s = fifo_empty;
    if (en_s) begin
      if (pops == 0) first_pop_cyc = cyc;
      last_pop_cyc = cyc;
      pops++;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (en_s) begin
      chk("pop_while_empty", 32'(empty_s), 32'd0);
      if (q.size() > 0) fifo_read_data = q.pop_front();
    end
    upd_empty();
  endtask

  task automatic load_weights(input logic [63:0] w);
    w_data = w;
    w_load = 1'b1;
    step();
    w_load = 1'b0;
  endtask

  task automatic wait_result(input string tag);
    for (int i = 0; i < 60; i++) begin
      if (result_valid) break;
      step();
    end
    chk(tag, 32'(result_valid), 32'd1);
  endtask

  task automatic wait_pops(input int n);
    for (int i = 0; i < 40; i++) begin
      if (pops >= n) break;
      step();
    end
    chk("pop_count_reached", 32'(pops), 32'(n));
  endtask

  initial begin
    rst_n          = 1'b0;
    w_load         = 1'b0;
    w_data         = '0;
    result_ready   = 1'b1;
    gap            = 1'b0;
    fifo_read_data = '0;
    upd_empty();
    step();
    step();
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_valid", 32'(result_valid), 32'd0);
    chk("rst_rd_en", 32'(fifo_read_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    step();

    // Unit weights, basic frame and latency.
    load_weights(W1);
    pops = 0;
    push_frame(F1);
    wait_result("t1_valid");
    chk("t1_result", 32'(result), 32'd10);
    chk("t1_pops", 32'(pops), 32'd8);
    chk("t1_burst", 32'(last_pop_cyc - first_pop_cyc), 32'd7);
    chk("t1_latency", 32'(cyc - last_pop_cyc), 32'd2);
    step();
    chk("t1_valid_pulse", 32'(result_valid), 32'd0);
    chk("t1_idle", 32'(busy), 32'd0);

    // Signed extremes.
    load_weights(W2);
    push_frame(F2);
    wait_result("t2_valid");
    chk("t2_result", 32'(result), 32'd1274);
    step();

    // FIFO runs dry after the third pop for five cycles.
    pops = 0;
    push_frame(F2);
    wait_pops(3);
    gap = 1'b1;
    upd_empty();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_gap_no_pop", 32'(en_s), 32'd0);
      chk("t3_gap_busy", 32'(busy), 32'd1);
    end
    gap = 1'b0;
    upd_empty();
    wait_result("t3_valid");
    chk("t3_result", 32'(result), 32'd1274);
    chk("t3_pops", 32'(pops), 32'd8);
    step();

    // Backpressure with a second frame queued.
    result_ready = 1'b0;
    pops = 0;
    push_frame(F2);
    push_frame(F4);
    wait_result("t4_valid");
    chk("t4_result_a", 32'(result), 32'd1274);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t4_hold_result", 32'(result), 32'd1274);
      chk("t4_hold_valid", 32'(result_valid), 32'd1);
      chk("t4_hold_no_pop", 32'(en_s), 32'd0);
    end
    chk("t4_pops_held", 32'(pops), 32'd8);
    result_ready = 1'b1;
    step();
    chk("t4_handshake_valid", 32'(result_valid), 32'd0);
    chk("t4_handshake_busy", 32'(busy), 32'd1);
    step();
    chk("t4_restart_pop", 32'(en_s), 32'd1);
    wait_result("t4_valid_b");
    chk("t4_result_b", 32'(result), 32'd2);
    step();

    // Weight load during RUN is ignored; reload in IDLE applies.
    push_frame(F1);
    step();
    chk("t5_busy", 32'(busy), 32'd1);
    w_data = WT;
    w_load = 1'b1;
    step();
    step();
    w_load = 1'b0;
    wait_result("t5_valid_old");
    chk("t5_old_weights", 32'(result), 32'd10);
    step();
    chk("t5_idle", 32'(busy), 32'd0);
    load_weights(WT);
    push_frame(F1);
    wait_result("t5_valid_new");
    chk("t5_new_weights", 32'(result), 32'd20);
    step();

    // Reset in the middle of a frame.
    pops = 0;
    push_frame(F1);
    wait_pops(4);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_valid", 32'(result_valid), 32'd0);
    chk("t6_rst_rd_en", 32'(fifo_read_en), 32'd0);
    chk("t6_rst_result", 32'(result), 32'd0);
    q.delete();
    upd_empty();
    step();
    step();
    rst_n = 1'b1;
    load_weights(W6);
    pops = 0;
    push_frame(F6);
    wait_result("t6_valid");
    chk("t6_result", 32'(result), 32'd8);
    chk("t6_pops", 32'(pops), 32'd8);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
